// File: rtl/cpu_pkg.sv
// cpu_pkg: fetch-stage state type and the ARM PC constants shared by the fetch RTL
package cpu_pkg;
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID, S_ERR} fetch_state_t;
    localparam int INSTR_WORD_BYTES = 4;
    localparam int PC_READ_OFFSET = 8;
endpackage

// File: rtl/instr_fetch_pc_reg.sv
// pc_reg: program counter with load enable; next value is pc+4 or the word-aligned target
//   clk, rst   : clock, asynchronous active-high reset (loads RESET_PC)
//   load       : update pc this cycle
//   sel_target : choose target instead of pc+4
//   target     : branch / PC-write target, low two bits ignored
//   pc         : current program counter
module pc_reg
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              sel_target,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);
    logic [ADDR_W-1:0] pc_next;
    always_comb pc_next = sel_target ? (target & ~ADDR_W'(3)) : pc + ADDR_W'(INSTR_WORD_BYTES);
    always_ff @(posedge clk or posedge rst)
        if (rst) pc <= RESET_PC;
        else if (load) pc <= pc_next;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, instruction-memory requests with wait-state timeout, valid/ready instruction output
//   clk, rst               : clock, asynchronous active-high reset
//   imem_req, imem_addr    : request and word-aligned address to instruction memory
//   imem_rdata, imem_ready : returned word and its strobe (only looked at while fetching)
//   instr, instr_valid     : held instruction and its valid flag
//   instr_ready            : downstream accepts instr
//   pc_src, pc_target      : take target instead of pc+4, sampled on the handshake only
//   pc, pc_plus8           : current instruction address and the ARM PC-read value
//   fetch_err              : sticky memory timeout, cleared only by rst
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int MAX_WAIT = 15
)(
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              pc_src,
    input  logic [ADDR_W-1:0] pc_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus8,
    output logic              fetch_err
);
    localparam int CNT_W = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
    fetch_state_t state, state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic timeout;
    logic handshake;
    // timeout fires on the cycle that would be wait MAX_WAIT+1, i.e. after MAX_WAIT+1 fetch cycles
    assign timeout = wait_cnt == CNT_W'(MAX_WAIT);
    assign handshake = state == S_VALID && instr_ready;
    pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc_reg (
        .clk(clk),
        .rst(rst),
        .load(handshake),
        .sel_target(pc_src),
        .target(pc_target),
        .pc(pc)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else state <= state_next;
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = S_FETCH;
            S_FETCH: state_next = imem_ready ? S_VALID : timeout ? S_ERR : S_FETCH;
            S_VALID: state_next = instr_ready ? S_FETCH : S_VALID;
            default: state_next = S_ERR;
        endcase
    end
    always_comb begin
        imem_req = state == S_FETCH;
        imem_addr = pc & ~ADDR_W'(3);
        instr_valid = state == S_VALID;
        pc_plus8 = pc + ADDR_W'(PC_READ_OFFSET);
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            instr <= '0;
            wait_cnt <= '0;
            fetch_err <= 1'b0;
        end else if (state == S_FETCH) begin
            if (imem_ready) begin
                instr <= imem_rdata;
                wait_cnt <= '0;
            end else if (timeout) fetch_err <= 1'b1;
            else wait_cnt <= wait_cnt + 1'b1;
        end
endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    localparam int MAX_WAIT = 15;
    logic clk = 0, rst = 1, rst_w = 1;
    logic imem_req, imem_ready, instr_valid, instr_ready, pc_src, fetch_err;
    logic [31:0] imem_addr, imem_rdata, instr, pc_target, pc, pc_plus8;
    logic imem_req_w, imem_ready_w, instr_valid_w, fetch_err_w;
    logic [31:0] imem_addr_w, imem_rdata_w, instr_w, pc_w, pc_plus8_w;
    logic instr_ready_w = 1'b1, pc_src_w = 1'b0;
    logic [31:0] pc_target_w = 32'h0;
    int compared = 0, mismatched = 0;
    int lat = 0, req_cyc = 0;
    logic [31:0] hs_pc[$], hs_instr[$], hs_p8[$];
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h000: return 32'he2800004;
            32'h004: return 32'he3a00000;
            32'h008: return 32'he35100ff;
            32'h00c: return 32'he1a00000;
            32'h010: return 32'h0a00003f;
            32'h114: return 32'he2811001;
            32'h118: return 32'he3510000;
            default: return a ^ 32'h5a5a0000;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // memory: answers lat cycles after the request first appears
    assign imem_ready = imem_req && req_cyc >= lat;
    assign imem_rdata = imem_ready ? mem(imem_addr) : 32'hdeadbeef;
    always @(posedge clk) req_cyc <= (imem_req && !imem_ready) ? req_cyc + 1 : 0;
    assign imem_ready_w = imem_req_w;
    assign imem_rdata_w = mem(imem_addr_w);

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .pc_src(pc_src),
        .pc_target(pc_target), .pc(pc), .pc_plus8(pc_plus8), .fetch_err(fetch_err)
    );
    instr_fetch #(.ADDR_W(32), .RESET_PC(32'hfffffffc), .MAX_WAIT(MAX_WAIT)) dut_w (
        .clk(clk), .rst(rst_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_rdata(imem_rdata_w), .imem_ready(imem_ready_w), .instr(instr_w),
        .instr_valid(instr_valid_w), .instr_ready(instr_ready_w), .pc_src(pc_src_w),
        .pc_target(pc_target_w), .pc(pc_w), .pc_plus8(pc_plus8_w), .fetch_err(fetch_err_w)
    );

    // behavioural model: one instruction either being fetched, being presented, or dead on timeout
    logic [31:0] m_pc, m_instr;
    logic m_have, m_err, m_started;
    int m_waits;
    always @(posedge clk or posedge rst)
        if (rst) begin
            m_pc <= 32'h0;
            m_instr <= 32'h0;
            m_have <= 1'b0;
            m_err <= 1'b0;
            m_started <= 1'b0;
            m_waits <= 0;
        end else if (!m_started) m_started <= 1'b1;
        else if (!m_err) begin
            if (m_have) begin
                if (instr_ready) begin
                    m_have <= 1'b0;
                    m_pc <= pc_src ? (pc_target & ~32'h3) : m_pc + 32'd4;
                end
            end else if (imem_ready) begin
                m_have <= 1'b1;
                m_instr <= mem(m_pc);
                m_waits <= 0;
            end else if (m_waits == MAX_WAIT) m_err <= 1'b1;
            else m_waits <= m_waits + 1;
        end

    always @(negedge clk)
        if (!rst) begin
            chk("imem_req", imem_req, m_started && !m_have && !m_err);
            if (m_started && !m_have && !m_err) chk("imem_addr", imem_addr, m_pc);
            chk("instr_valid", instr_valid, m_have);
            if (m_have) chk("instr", instr, m_instr);
            chk("pc", pc, m_pc);
            chk("pc_plus8", pc_plus8, m_pc + 32'd8);
            chk("fetch_err", fetch_err, m_err);
            if (instr_valid && instr_ready) begin
                hs_pc.push_back(pc);
                hs_instr.push_back(instr);
                hs_p8.push_back(pc_plus8);
            end
        end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid_pc(input logic [31:0] a);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(instr_valid && pc == a) && n < 60);
        chk("wait_valid_pc", {31'b0, instr_valid && pc == a}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] hold_pc, hold_instr;
        instr_ready = 1; pc_src = 0; pc_target = 0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", pc, 0);
        chk("rst_pc_plus8", pc_plus8, 32'h8);
        chk("rst_err", fetch_err, 0);
        @(posedge clk);
        #2 rst = 0;
        // sequential zero-wait fetch up to pc 0x10
        wait_valid_pc(32'h10);
        chk("seq_count", hs_pc.size(), 4);
        chk("seq_pc0", hs_pc[0], 32'h0);
        chk("seq_pc1", hs_pc[1], 32'h4);
        chk("seq_pc2", hs_pc[2], 32'h8);
        chk("seq_i0", hs_instr[0], 32'he2800004);
        chk("seq_i1", hs_instr[1], 32'he3a00000);
        chk("seq_i2", hs_instr[2], 32'he35100ff);
        chk("seq_p80", hs_p8[0], 32'h8);
        chk("seq_p81", hs_p8[1], 32'hc);
        chk("seq_p82", hs_p8[2], 32'h10);
        // branch at 0x10 to 0x114
        chk("br_instr", instr, 32'h0a00003f);
        pc_src = 1; pc_target = 32'h114;
        tick();
        pc_src = 0;
        chk("br_req", imem_req, 1);
        chk("br_addr", imem_addr, 32'h114);
        wait_valid_pc(32'h114);
        chk("br_fetched", instr, 32'he2811001);
        // branch back to 0x10 through a misaligned target
        pc_src = 1; pc_target = 32'h13;
        tick();
        chk("br2_addr", imem_addr, 32'h10);
        pc_target = 32'h200;
        wait_valid_pc(32'h10);
        pc_target = 32'h117;
        tick();
        pc_src = 0;
        instr_ready = 0;
        chk("br_misalign_addr", imem_addr, 32'h114);
        // wait states and backpressure
        wait_valid_pc(32'h114);
        lat = 3;
        instr_ready = 1;
        tick();
        instr_ready = 0;
        n = 0;
        while (!instr_valid && n < 20) begin
            if (imem_req) n++;
            tick();
        end
        chk("ws_req_cycles", n, 4);
        chk("ws_pc", pc, 32'h118);
        chk("ws_instr", instr, 32'he3510000);
        hold_pc = pc; hold_instr = instr;
        repeat (4) begin
            tick();
            chk("bp_valid", instr_valid, 1);
            chk("bp_req", imem_req, 0);
            chk("bp_pc", pc, hold_pc);
            chk("bp_instr", instr, hold_instr);
        end
        instr_ready = 1;
        lat = 1000;
        tick();
        chk("bp_next_pc", pc, 32'h11c);
        // timeout with a memory that never answers
        n = 0;
        while (!fetch_err && n < 40) begin
            if (imem_req) n++;
            tick();
        end
        chk("to_cycles", n, MAX_WAIT + 1);
        chk("to_req", imem_req, 0);
        chk("to_valid", instr_valid, 0);
        chk("to_pc", pc, 32'h11c);
        repeat (3) tick();
        chk("to_sticky", fetch_err, 1);
        chk("to_req_idle", imem_req, 0);
        rst = 1;
        #1;
        chk("to_rst_err", fetch_err, 0);
        chk("to_rst_pc", pc, 32'h0);
        chk("to_rst_req", imem_req, 0);
        lat = 0;
        tick();
        rst = 0;
        wait_valid_pc(32'h0);
        chk("to_refetch", instr, 32'he2800004);
        // reset two cycles into a 5-wait fetch
        lat = 5;
        tick();
        tick();
        chk("mid_req_before", imem_req, 1);
        chk("mid_addr_before", imem_addr, 32'h4);
        rst = 1;
        #1;
        chk("mid_req", imem_req, 0);
        chk("mid_valid", instr_valid, 0);
        chk("mid_pc", pc, 32'h0);
        tick();
        lat = 0;
        rst = 0;
        wait_valid_pc(32'h0);
        chk("mid_refetch0", instr, 32'he2800004);
        wait_valid_pc(32'h4);
        chk("mid_refetch4", instr, 32'he3a00000);
        // wrap-around instance
        tick();
        rst_w = 0;
        chk("wr_pc", pc_w, 32'hfffffffc);
        chk("wr_pc_plus8", pc_plus8_w, 32'h4);
        chk("wr_idle_req", imem_req_w, 0);
        tick();
        chk("wr_req", imem_req_w, 1);
        chk("wr_addr", imem_addr_w, 32'hfffffffc);
        tick();
        chk("wr_valid", instr_valid_w, 1);
        chk("wr_instr", instr_w, 32'ha5a5fffc);
        tick();
        chk("wr_next_pc", pc_w, 32'h0);
        chk("wr_next_p8", pc_plus8_w, 32'h8);
        chk("wr_next_req", imem_req_w, 1);
        chk("wr_next_addr", imem_addr_w, 32'h0);
        chk("wr_err", fetch_err_w, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage of the single-cycle ARM CPU, directly upstream of the instruction splitter and control unit.
- Holds the program counter and issues requests to the instruction memory, which may insert wait states.
- Presents each fetched 32-bit instruction through a valid/ready handshake.
- Advances the PC on handshake to PC+4, or to the branch/PC-write target when the control unit asserts PC_SRC.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address
RESET_PC, 32'h0000_0000, PC value loaded on reset (low 2 bits must be 0)
MAX_WAIT, 15, wait cycles allowed per fetch before fetch_err asserts

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  fetch address, equals pc with bits [1:0] = 0
imem_rdata  in  32  instruction word from memory, valid when imem_ready
imem_ready  in  1  memory has data this cycle
instr  out  32  registered fetched instruction, to splitter
instr_valid  out  1  instr holds an unconsumed instruction
instr_ready  in  1  downstream consumes instr this cycle
pc_src  in  1  PC_SRC from control unit; sampled only on handshake
pc_target  in  ADDR_W  next PC when pc_src=1 (branch target / ALU result)
pc  out  ADDR_W  address of current instruction
pc_plus8  out  ADDR_W  pc+8, ARM PC-read value for the datapath
fetch_err  out  1  sticky memory-timeout flag

Behaviour:
- Reset values (asynchronous on rst):
  - pc = RESET_PC; state = S_IDLE
  - imem_req = 0; instr = 32'h0; instr_valid = 0; fetch_err = 0; wait_cnt = 0
- States and transitions:
  - S_IDLE: entered only from reset. Moves to S_FETCH on the first clock edge after rst deasserts.
  - S_FETCH: imem_req = 1, imem_addr = {pc[ADDR_W-1:2], 2'b00}.
    - If imem_ready: instr <= imem_rdata, instr_valid <= 1, wait_cnt <= 0, go to S_VALID.
    - Else wait_cnt increments. If wait_cnt == MAX_WAIT and imem_ready = 0: fetch_err <= 1, go to S_ERR.
  - S_VALID: imem_req = 0; instr and pc held stable.
    - If instr_ready: pc <= pc_src ? {pc_target[ADDR_W-1:2], 2'b00} : pc + 4; instr_valid <= 0; go to S_FETCH.
  - S_ERR: imem_req = 0, instr_valid = 0, pc frozen. Exits only on rst.
- Latency:
  - imem_ready sampled at edge N means instr_valid = 1 from N.
  - Zero-wait memory gives one instruction every 2 cycles (fetch, present).
  - The new pc appears the cycle after the handshake.
- Combinational outputs: imem_req and imem_addr are decoded from state and pc; pc_plus8 = pc + 8 at all times.
- Arithmetic: all PC arithmetic is unsigned modulo 2^ADDR_W. pc = 0xFFFFFFFC with pc_src = 0 goes to 0x00000000; pc_plus8 wraps to 0x00000004.
- Misaligned pc_target: bits [1:0] are silently cleared.
- imem_ready outside S_FETCH is ignored.
- pc_src / pc_target outside the handshake cycle are ignored.
- Reset mid-fetch: imem_req drops immediately (async) and the outstanding request is abandoned.
- instr_ready held high continuously: each S_VALID lasts exactly one cycle.

Decomposition:
- Package cpu_pkg holds:
  - fetch_state_t enum {S_IDLE, S_FETCH, S_VALID, S_ERR}
  - constant INSTR_WORD_BYTES = 4
  - constant PC_READ_OFFSET = 8
- One sub-module, pc_reg: the asynchronous-reset PC register with load enable and next-PC mux (pc+4 vs aligned target).
- FSM and wait counter stay in instr_fetch.

Test Plan:
- Sequential fetch: zero-wait memory (0x0 = e2800004, 0x4 = e3a00000, 0x8 = e35100ff), instr_ready = 1.
  - Expect instr sequence e2800004, e3a00000, e35100ff on consecutive valid cycles.
  - Expect pc 0x0, 0x4, 0x8 and pc_plus8 0x8, 0xC, 0x10.
- Branch taken: at pc = 0x10 with instr 0a00003f, pc_src = 1, pc_target = 0x114 on handshake.
  - Expect the next imem_addr = 0x114, then instr from 0x114.
  - Also drive pc_target = 0x117; expect 0x114.
- Wait states and backpressure: memory asserts imem_ready 3 cycles after imem_req, and instr_ready is held low 4 cycles.
  - Expect instr_valid with instr stable and pc unchanged throughout.
  - Expect imem_req = 0 during S_VALID; fetch advances only after instr_ready.
- Timeout: MAX_WAIT = 15, imem_ready never asserts.
  - Expect fetch_err = 1 after 16 S_FETCH cycles, then imem_req = 0 and fetch_err sticky.
  - Then pulse rst; expect fetch_err = 0 and a fetch from RESET_PC.
- Wrap-around: RESET_PC = 0xFFFFFFFC, pc_src = 0.
  - Expect pc_plus8 = 0x00000004 while pc = 0xFFFFFFFC.
  - After handshake, expect imem_addr = 0x00000000.
- Reset mid-fetch: assert rst two cycles into a 5-wait fetch.
  - Expect imem_req = 0 and instr_valid = 0 within the same cycle, pc = RESET_PC.
  - Expect a clean fetch from RESET_PC after release.
